// File: rtl/cpu_dma_rd_arbiter_if.sv
// Read-side bus between the CPU DMA queues, the queue arbiter and the DMA engine.
// The slave view belongs to the arbiter; the master view is the queues plus engine side.
interface cpu_dma_rd_arbiter_if #(
   parameter int NUM_QUEUES     = 4,
   parameter int DMA_DATA_WIDTH = 32,
   parameter int DMA_CTRL_WIDTH = DMA_DATA_WIDTH / 8,
   parameter int SEL_WIDTH      = $clog2(NUM_QUEUES)
);
   logic [NUM_QUEUES-1:0]                q_en;
   logic [NUM_QUEUES-1:0]                q_pkt_avail;
   logic [NUM_QUEUES-1:0]                q_rd_rdy;
   logic [NUM_QUEUES-1:0]                q_rd;
   logic [NUM_QUEUES*DMA_DATA_WIDTH-1:0] q_rd_data;
   logic [NUM_QUEUES*DMA_CTRL_WIDTH-1:0] q_rd_ctrl;
   logic                                 dma_pkt_avail;
   logic [SEL_WIDTH-1:0]                 dma_q_sel;
   logic                                 dma_rd_rdy;
   logic                                 dma_rd;
   logic [DMA_DATA_WIDTH-1:0]            dma_rd_data;
   logic [DMA_CTRL_WIDTH-1:0]            dma_rd_ctrl;
   logic [11:0]                          dma_pkt_words;
   logic                                 dma_proto_err;

   modport slave (
      input  q_en, q_pkt_avail, q_rd_rdy, q_rd_data, q_rd_ctrl, dma_rd,
      output q_rd, dma_pkt_avail, dma_q_sel, dma_rd_rdy, dma_rd_data, dma_rd_ctrl,
             dma_pkt_words, dma_proto_err
   );

   modport master (
      output q_en, q_pkt_avail, q_rd_rdy, q_rd_data, q_rd_ctrl, dma_rd,
      input  q_rd, dma_pkt_avail, dma_q_sel, dma_rd_rdy, dma_rd_data, dma_rd_ctrl,
             dma_pkt_words, dma_proto_err
   );
endinterface

// File: rtl/cpu_dma_rd_arbiter.sv
// Round-robin, packet-locked arbiter sharing one DMA read channel among CPU DMA queues.
// The grant is held from arbitration until the DMA engine accepts the end-of-packet word.
module cpu_dma_rd_arbiter #(
   parameter int NUM_QUEUES     = 4,
   parameter int SEL_WIDTH      = $clog2(NUM_QUEUES),
   parameter int DMA_DATA_WIDTH = 32,
   parameter int DMA_CTRL_WIDTH = DMA_DATA_WIDTH / 8
) (
   input logic                 clk,
   input logic                 reset_n,
   cpu_dma_rd_arbiter_if.slave bus
);
   typedef enum logic {IDLE, XFER} state_t;

   state_t                    r_state;
   logic [SEL_WIDTH-1:0]      r_grant;
   logic [SEL_WIDTH-1:0]      r_last_grant;
   logic [11:0]               r_word_cnt;
   logic                      r_proto_err;

   logic [NUM_QUEUES-1:0]     w_req;
   logic [SEL_WIDTH-1:0]      w_winner;
   logic [SEL_WIDTH-1:0]      w_cand;
   logic                      w_found;
   logic                      w_xfer;
   logic                      w_rdy;
   logic                      w_accept;
   logic                      w_eop;
   logic [DMA_DATA_WIDTH-1:0] w_data;
   logic [DMA_CTRL_WIDTH-1:0] w_ctrl;

   assign w_req    = bus.q_pkt_avail & bus.q_en;
   assign w_xfer   = (r_state == XFER);
   assign w_rdy    = w_xfer & bus.q_rd_rdy[r_grant];
   assign w_accept = bus.dma_rd & w_rdy;
   assign w_data   = w_xfer ? bus.q_rd_data[int'(r_grant)*DMA_DATA_WIDTH +: DMA_DATA_WIDTH] : '0;
   assign w_ctrl   = w_xfer ? bus.q_rd_ctrl[int'(r_grant)*DMA_CTRL_WIDTH +: DMA_CTRL_WIDTH] : '0;
   assign w_eop    = w_accept & (|w_ctrl);

   // Search starts just past the last granted queue; the queue count is a power of
   // two, so the select adder wraps modulo NUM_QUEUES on its own.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_cand   = '0;
      for (int k = 1; k <= NUM_QUEUES; k++) begin
         w_cand = r_last_grant + SEL_WIDTH'(k);
         if (!w_found && w_req[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_QUEUES; gi++) begin : g_q_rd
         assign bus.q_rd[gi] = w_accept & (r_grant == SEL_WIDTH'(gi));
      end
   endgenerate

   assign bus.dma_pkt_avail = w_xfer;
   assign bus.dma_q_sel     = r_grant;
   assign bus.dma_rd_rdy    = w_rdy;
   assign bus.dma_rd_data   = w_data;
   assign bus.dma_rd_ctrl   = w_ctrl;
   assign bus.dma_pkt_words = r_word_cnt;
   assign bus.dma_proto_err = r_proto_err;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_grant      <= '0;
         r_last_grant <= SEL_WIDTH'(NUM_QUEUES - 1);
         r_word_cnt   <= '0;
         r_proto_err  <= 1'b0;
      end else begin
         // Any read that is not backed by a ready granted queue is illegal.
         r_proto_err <= bus.dma_rd & ~w_rdy;
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_grant    <= w_winner;
                  r_word_cnt <= '0;
                  r_state    <= XFER;
               end
            end
            XFER: begin
               if (w_accept) begin
                  if (r_word_cnt != 12'hFFF) begin
                     r_word_cnt <= r_word_cnt + 12'd1;
                  end
                  if (w_eop) begin
                     r_last_grant <= r_grant;
                     r_state      <= IDLE;
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: doc/cpu_dma_rd_arbiter.md
# cpu_dma_rd_arbiter

Shares the single DMA read channel of the CPCI interface among NUM_QUEUES CPU DMA queues. Each queue offers packets headed for the host; the block grants one queue at a time in round-robin order and locks the grant for a whole packet. It then muxes the granted queue's read handshake and data onto the DMA engine side. It sits between the per-port CPU DMA queues and the DMA engine, alongside the queue-enable register bits.

## Interface
Parameters:
- NUM_QUEUES, 4: number of CPU DMA queues; power of two, 2..8.
- SEL_WIDTH, log2(NUM_QUEUES): width of the queue select.
- DMA_DATA_WIDTH, 32: DMA word width.
- DMA_CTRL_WIDTH, DMA_DATA_WIDTH/8: DMA ctrl width.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- q_en  in  NUM_QUEUES  per-queue enable from the queue registers; a disabled queue is never granted.
- q_pkt_avail  in  NUM_QUEUES  queue i holds at least one complete packet.
- q_rd_rdy  in  NUM_QUEUES  queue i can supply a word this cycle.
- q_rd  out  NUM_QUEUES  read strobe to queue i.
- q_rd_data  in  NUM_QUEUES*DMA_DATA_WIDTH  read data; slice i belongs to queue i; first-word-fall-through.
- q_rd_ctrl  in  NUM_QUEUES*DMA_CTRL_WIDTH  ctrl; a nonzero value marks the last word of the packet.
- dma_pkt_avail  out  1  a granted packet is in progress.
- dma_q_sel  out  SEL_WIDTH  index of the granted queue.
- dma_rd_rdy  out  1  the granted queue is ready.
- dma_rd  in  1  read strobe from the DMA engine.
- dma_rd_data  out  DMA_DATA_WIDTH  data of the granted queue.
- dma_rd_ctrl  out  DMA_CTRL_WIDTH  ctrl of the granted queue.
- dma_pkt_words  out  12  word count of the current or last packet.
- dma_proto_err  out  1  one-cycle pulse flagging an illegal read.

## Operation
- States: IDLE and XFER.
- IDLE:
  - req = q_pkt_avail & q_en.
  - If req ≠ 0, the winner is the first set bit searched from last_grant+1 upward, wrapping modulo NUM_QUEUES.
  - Register grant ← winner; clear word_cnt; go to XFER.
- XFER:
  - dma_pkt_avail = 1; dma_q_sel = grant.
  - dma_rd_rdy = q_rd_rdy[grant].
  - q_rd[grant] = dma_rd & q_rd_rdy[grant]; all other q_rd bits = 0.
  - dma_rd_data and dma_rd_ctrl are combinational muxes of the grant slice. In IDLE they are 0.
  - Each accepted word (dma_rd & dma_rd_rdy) increments word_cnt. word_cnt saturates at 4095.
  - An accepted word with nonzero ctrl is end of packet (EOP): last_grant ← grant; go to IDLE.
- The grant is held until EOP. It does not change when the granted queue drops q_pkt_avail or q_en mid-packet, or when other queues request.
- dma_pkt_words is the registered word_cnt. It holds its value through IDLE until the next grant clears it.
- dma_proto_err pulses for 1 cycle, registered, when dma_rd = 1 in either of these cases:
  - state is IDLE, or
  - dma_rd_rdy = 0.
- A flagged read produces no q_rd and no count.

## Timing
- Reset values:
  - state IDLE, grant 0, last_grant NUM_QUEUES-1, so queue 0 has first priority.
  - dma_pkt_avail 0, dma_q_sel 0, dma_pkt_words 0, dma_proto_err 0.
  - q_rd 0, dma_rd_rdy 0, dma_rd_data 0, dma_rd_ctrl 0.
- Grant latency: req seen in IDLE in cycle N → dma_pkt_avail = 1 and the new dma_q_sel in cycle N+1.
- EOP accepted in cycle M → dma_pkt_avail = 0 in M+1 (IDLE, arbitrating) → next grant visible in M+2. There is a minimum 1 idle cycle between packets.
- Read path is zero latency: dma_rd → q_rd in the same cycle, and data and ctrl are valid in the same cycle.
- A single-word packet (ctrl ≠ 0 on the first word) completes in 1 XFER cycle.
- A reset_n assertion mid-packet forces IDLE and the reset values immediately. The partial packet is abandoned; the queue owns recovery.

## Test plan
- Reset, then q_pkt_avail = 4'b0001 with q_en = 4'hF → dma_pkt_avail = 1 one cycle later, dma_q_sel = 0. 3 words read with ctrl 0,0,0x8 → IDLE next cycle; dma_pkt_words = 3.
- All 4 queues request continuously, each with 2-word packets → grant order 0,1,2,3,0. Each grant follows a 1-cycle IDLE gap.
- Queue 2 granted; queue 0 requests mid-packet, and queue 2 drops q_pkt_avail after word 1 → grant stays 2 until EOP, then goes to 0.
- q_en = 4'b1101 with q_pkt_avail = 4'hF → queue 1 is never granted; order 0,2,3,0.
- dma_rd pulsed in IDLE, and separately during XFER with q_rd_rdy[grant] = 0 → dma_proto_err = 1 for one cycle each. q_rd stays 0 and word_cnt does not change.
- reset_n asserted after 2 of 5 words → all outputs return to reset values asynchronously. After release, queue 0 is granted first.
